// File: rtl/mano_timing_ctrl.sv
// Mano basic computer timing and control unit.
// Drives the sequence counter and decodes it, together with the latched
// I bit and opcode, into per-cycle datapath control strobes.
module mano_timing_ctrl #(
  parameter int SC_W   = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       ir_in,
  input  logic              dr_zero,
  input  logic              ac_zero,
  input  logic              ac_neg,
  output logic [2:0]        bus_sel,
  output logic              ar_ld,
  output logic              ar_inc,
  output logic              pc_ld,
  output logic              pc_inc,
  output logic              dr_ld,
  output logic              dr_inc,
  output logic              ac_ld,
  output logic              ac_clr,
  output logic              ir_ld,
  output logic              tr_ld,
  output logic              mem_wr,
  output logic              e_clr,
  output logic [2:0]        alu_op,
  output logic [SC_W-1:0]   sc,
  output logic              halted
);

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_e;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_AND  = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_CMA  = 3'd3,
    ALU_INC  = 3'd4
  } alu_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_RIO = 3'd7
  } opcode_e;

  localparam logic [SC_W-1:0] T0 = '0;
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T4 = SC_W'(4);
  localparam logic [SC_W-1:0] T5 = SC_W'(5);
  localparam logic [SC_W-1:0] T6 = SC_W'(6);

  localparam logic [ADDR_W-1:0] RR_CLA = ADDR_W'(12'h800);
  localparam logic [ADDR_W-1:0] RR_CMA = ADDR_W'(12'h200);
  localparam logic [ADDR_W-1:0] RR_INC = ADDR_W'(12'h020);
  localparam logic [ADDR_W-1:0] RR_SZA = ADDR_W'(12'h004);
  localparam logic [ADDR_W-1:0] RR_SPA = ADDR_W'(12'h010);
  localparam logic [ADDR_W-1:0] RR_HLT = ADDR_W'(12'h001);

  logic [SC_W-1:0] sc_n;
  logic            halted_n;
  logic            ind_q, ind_n;
  opcode_e         op_q, op_n;
  bus_e            bus_c;
  alu_e            alu_c;

  assign bus_sel = bus_c;
  assign alu_op  = alu_c;

  // State register: sequence counter, halt flag, I/opcode latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc     <= '0;
      halted <= 1'b0;
      ind_q  <= 1'b0;
      op_q   <= OP_AND;
    end else begin
      sc     <= sc_n;
      halted <= halted_n;
      ind_q  <= ind_n;
      op_q   <= op_n;
    end
  end

  // Next-state and control-word decode from timing step, latches and flags.
  always_comb begin
    sc_n     = sc + SC_W'(1);
    halted_n = halted;
    ind_n    = ind_q;
    op_n     = op_q;
    bus_c    = BUS_NONE;
    alu_c    = ALU_PASS;
    ar_ld    = 1'b0;
    ar_inc   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    dr_ld    = 1'b0;
    dr_inc   = 1'b0;
    ac_ld    = 1'b0;
    ac_clr   = 1'b0;
    ir_ld    = 1'b0;
    tr_ld    = 1'b0;
    mem_wr   = 1'b0;
    e_clr    = 1'b0;

    if (sc > T6) begin
      sc_n = '0;
    end else if (halted) begin
      sc_n = '0;
      if (run) halted_n = 1'b0;
    end else begin
      case (sc)
        T0: begin
          bus_c = BUS_PC;
          ar_ld = 1'b1;
        end
        T1: begin
          bus_c  = BUS_MEM;
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
        end
        T2: begin
          bus_c = BUS_IR;
          ar_ld = 1'b1;
          ind_n = ir_in[15];
          op_n  = opcode_e'(ir_in[14:12]);
        end
        T3: begin
          if (op_q == OP_RIO) begin
            sc_n = '0;
            if (!ind_q) begin
              case (ir_in[ADDR_W-1:0])
                RR_CLA: ac_clr = 1'b1;
                RR_CMA: begin alu_c = ALU_CMA; ac_ld = 1'b1; end
                RR_INC: begin alu_c = ALU_INC; ac_ld = 1'b1; end
                RR_SZA: pc_inc = ac_zero;
                RR_SPA: pc_inc = !ac_neg;
                RR_HLT: halted_n = 1'b1;
                default: ;
              endcase
            end
          end else if (ind_q) begin
            bus_c = BUS_MEM;
            ar_ld = 1'b1;
          end
        end
        T4: begin
          case (op_q)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_c = BUS_MEM;
              dr_ld = 1'b1;
            end
            OP_STA: begin
              bus_c  = BUS_AC;
              mem_wr = 1'b1;
              sc_n   = '0;
            end
            OP_BUN: begin
              bus_c = BUS_AR;
              pc_ld = 1'b1;
              sc_n  = '0;
            end
            OP_BSA: begin
              bus_c  = BUS_PC;
              mem_wr = 1'b1;
              ar_inc = 1'b1;
            end
            default: sc_n = '0;
          endcase
        end
        T5: begin
          sc_n = '0;
          case (op_q)
            OP_AND: begin alu_c = ALU_AND;  ac_ld = 1'b1; end
            OP_ADD: begin alu_c = ALU_ADD;  ac_ld = 1'b1; end
            OP_LDA: begin alu_c = ALU_PASS; ac_ld = 1'b1; end
            OP_BSA: begin bus_c = BUS_AR;   pc_ld = 1'b1; end
            OP_ISZ: begin
              dr_inc = 1'b1;
              sc_n   = T6;
            end
            default: ;
          endcase
        end
        T6: begin
          sc_n = '0;
          if (op_q == OP_ISZ) begin
            bus_c  = BUS_DR;
            mem_wr = 1'b1;
            pc_inc = dr_zero;
          end
        end
        default: sc_n = '0;
      endcase
    end

    // Strobes are combinational, so they are forced low for as long as
    // reset is held rather than only after the registers clear.
    if (!reset) begin
      bus_c  = BUS_NONE;
      alu_c  = ALU_PASS;
      ar_ld  = 1'b0;
      ar_inc = 1'b0;
      pc_ld  = 1'b0;
      pc_inc = 1'b0;
      dr_ld  = 1'b0;
      dr_inc = 1'b0;
      ac_ld  = 1'b0;
      ac_clr = 1'b0;
      ir_ld  = 1'b0;
      mem_wr = 1'b0;
    end
  end

endmodule
